// File: rtl/sm_addsub_seq.sv
// Bit-serial sign-magnitude adder/subtractor with start/done handshake.
// Build option: define SM_ADDSUB_SAT_EN to saturate the magnitude on overflow (default wraps).
module sm_addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_NEG, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [M-1:0]   r_amag;
  logic [M-1:0]   r_bmag;
  logic [M-1:0]   r_acc;
  logic           r_carry;
  logic           r_sa;
  logic           r_sb;
  logic           r_diff;
  logic [WIDTH-1:0] r_result;
  logic           r_ovf;

  logic           w_accept;
  logic           w_last;
  logic           w_abit;
  logic           w_bbit;
  logic           w_bit;
  logic           w_cout;
  logic           w_neg_bit;
  logic           w_neg_cout;
  logic           w_go_neg;
  logic [M-1:0]   w_add_mag;
  logic [M-1:0]   w_neg_mag;

  // Packs sign and magnitude; a zero magnitude always carries a positive sign.
  function automatic logic [WIDTH-1:0] f_pack(input logic sign, input logic [M-1:0] mag,
                                              input logic of);
    logic [WIDTH-1:0] res;
`ifdef SM_ADDSUB_SAT_EN
    if (of) res = {sign, {M{1'b1}}};
    else    res = {sign & (|mag), mag};
`else
    res = {sign & (|mag) & ~(of & ~(|mag)), mag};
`endif
    return res;
  endfunction

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == CW'(M - 1));

  always_comb begin
    w_abit     = r_amag[0];
    w_bbit     = r_bmag[0];
    w_bit      = w_abit ^ w_bbit ^ r_carry;
    if (r_diff) w_cout = (~w_abit & w_bbit) | (~(w_abit ^ w_bbit) & r_carry);
    else        w_cout = (w_abit & w_bbit) | (r_carry & (w_abit ^ w_bbit));
    w_neg_bit  = ~r_acc[0] ^ r_carry;
    w_neg_cout = ~r_acc[0] & r_carry;
    w_add_mag  = {w_bit, r_acc[M-1:1]};
    w_neg_mag  = {w_neg_bit, r_acc[M-1:1]};
    w_go_neg   = r_diff & w_cout;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_ADD;
      S_ADD: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = w_go_neg ? S_NEG : S_DONE;
      end
      S_NEG: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_ADD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_amag   <= '0;
      r_bmag   <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_diff   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Negative zero is folded to +0 before the subtract flips b's sign.
      r_amag  <= a[M-1:0];
      r_bmag  <= b[M-1:0];
      r_sa    <= a[WIDTH-1] & (|a[M-1:0]);
      r_sb    <= (b[WIDTH-1] & (|b[M-1:0])) ^ op;
      r_diff  <= (a[WIDTH-1] & (|a[M-1:0])) ^ (b[WIDTH-1] & (|b[M-1:0])) ^ op;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_ADD) begin
      r_amag  <= r_amag >> 1;
      r_bmag  <= r_bmag >> 1;
      r_acc   <= w_add_mag;
      r_carry <= w_cout;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        if (w_go_neg) begin
          r_carry <= 1'b1;
        end else begin
          r_result <= f_pack(r_sa, w_add_mag, ~r_diff & w_cout);
          r_ovf    <= ~r_diff & w_cout;
        end
      end
    end else if (r_state == S_NEG) begin
      // Two's-complement the borrowed difference: invert and add the seeded carry.
      r_acc   <= w_neg_mag;
      r_carry <= w_neg_cout;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_result <= f_pack(r_sb, w_neg_mag, 1'b0);
        r_ovf    <= 1'b0;
      end
    end
  end

  assign result = r_result;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Directed bench for sm_addsub_seq (WIDTH=16): vector table plus handshake/reset sequences.
module tb_sm_addsub_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef SM_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  sm_addsub_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vop;
    logic [15:0] eres;
    logic        eovf;
    int          elat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge accepts the request.
  task automatic go(input logic [15:0] ta, input logic [15:0] tb_, input logic top,
                    output int lat, output int bcnt);
    start = 1'b1; a = ta; b = tb_; op = top;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 16};
    vecs[1]  = '{16'h0003, 16'h8005, 1'b0, 16'h8002, 1'b0, 31};
    vecs[2]  = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 16};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 16};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h0000, 1'b1, 16};
    vecs[5]  = '{16'hFFFF, 16'h8001, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 16};
    vecs[6]  = '{16'h8007, 16'h0002, 1'b1, 16'h8009, 1'b0, 16};
    vecs[7]  = '{16'h0002, 16'h0007, 1'b1, 16'h8005, 1'b0, 31};
    vecs[8]  = '{16'h8003, 16'h0003, 1'b0, 16'h0000, 1'b0, 16};
    vecs[9]  = '{16'h8002, 16'h0009, 1'b0, 16'h0007, 1'b0, 31};
    vecs[10] = '{16'h1234, 16'h0F00, 1'b0, 16'h2134, 1'b0, 16};
    vecs[11] = '{16'h4000, 16'h4000, 1'b0, SAT ? 16'h7FFF : 16'h0000, 1'b1, 16};
    vecs[12] = '{16'h8000, 16'h8001, 1'b1, 16'h0001, 1'b0, 16};
    vecs[13] = '{16'h0005, 16'h8000, 1'b1, 16'h0005, 1'b0, 16};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b0;

    // Each vector is issued in the done cycle of the previous one (back-to-back).
    for (int i = 0; i < 14; i++) begin
      go(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, bcnt);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_busy", i), bcnt, vecs[i].elat - 1);
      chk($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, vecs[i].eres});
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].eovf});
    end

    repeat (3) @(posedge clk);
    #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_result", {16'd0, result}, {16'd0, vecs[13].eres});

    // Start pulsed mid-operation with other operands must be ignored.
    start = 1'b1; a = 16'h0005; b = 16'h0003; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 16'h0100; b = 16'h0200; op = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 16);
    chk("ign_result", {16'd0, result}, 32'h0008);
    @(posedge clk); #1;
    chk("ign_no_second_op", {30'd0, busy, done}, 32'd0);

    // Reset 8 cycles into a NEG-path operation.
    start = 1'b1; a = 16'h0003; b = 16'h8005; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b0;
    go(16'h0002, 16'h0007, 1'b0, lat, bcnt);
    chk("post_rst_lat", lat, 16);
    chk("post_rst_result", {16'd0, result}, 32'h0009);
    chk("post_rst_ovf", {31'd0, ovf}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_addsub_seq.md
# sm_addsub_seq

Parametrised, bit-serial sign-magnitude adder/subtractor with a start/done handshake. It is the sequential successor to the team's 16-bit combinational signed adder. It resolves the result sign correctly for mixed-sign operands, supports subtraction, never produces negative zero, and flags magnitude overflow. It sits beside the ALU datapath wherever area matters more than latency.

## Interface
- WIDTH, 16, total operand/result width: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude; M = WIDTH-1; legal range 3..64
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only when busy=0
- op  input  1  0 = a+b, 1 = a-b; latched with operands
- a  input  WIDTH  sign-magnitude operand; latched at accept
- b  input  WIDTH  sign-magnitude operand; latched at accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result and ovf are valid from this cycle
- result  output  WIDTH  sign-magnitude sum/difference; held until the next done or reset
- ovf  output  1  magnitude overflow of the last operation; held with result

## Operation
- Accept: start=1 while busy=0 (state IDLE or DONE) latches a, b and op. When op=1, the effective sign of b is inverted.
- Negative zero (sign=1, magnitude=0) on either input is treated as +0.
- States are IDLE, ADD, NEG and DONE. Transitions:
  - IDLE to ADD on accept.
  - ADD to NEG after M cycles if a negation is required; otherwise ADD to DONE.
  - NEG to DONE after M cycles.
  - DONE to ADD on accept; otherwise DONE to IDLE.
- ADD processes magnitudes LSB first, one bit per cycle, with a 1-bit carry/borrow register.
  - Equal effective signs: magnitude add. The result sign is a's sign. A final carry sets ovf.
  - Differing signs: computes |a|-|b|. If there is no final borrow, the result sign is a's sign. If there is a final borrow, NEG is entered.
- NEG performs a serial two's-complement negation of the difference register, LSB first, over M cycles. The result sign is b's effective sign. ovf is always 0 on this path.
- Zero magnitude result: the sign is forced to 0 on every path.
- Overflow handling is selected at build time (see Configuration). ovf is reported regardless of build.
- A start received while busy=1 is ignored: no queueing, and the latched operands are unchanged.
- Reset at any time, including mid-operation, forces: state IDLE, busy=0, done=0, result=0, ovf=0, internal shift and carry registers cleared. Start is accepted on the first cycle after reset is deasserted.

## Timing
- Accept at edge T. ADD spans cycles T+1..T+M, processing bit i in cycle T+1+i.
- Without negation: done=1 in cycle T+M+1, so latency is M+1 cycles.
- With negation: NEG spans T+M+1..T+2M, and done=1 in cycle T+2M+1, so latency is 2M+1 cycles.
- busy=1 from T+1 through the last ADD/NEG cycle. busy=0 in the done cycle.
- result and ovf update in the same cycle that done rises. They do not change between done pulses.
- Back-to-back operation: a start in the done cycle is accepted, and the next done follows with the same latency.

## Configuration
- SM_ADDSUB_SAT_EN
  - Defined: on overflow, the result magnitude saturates to all ones and the sign is kept. For WIDTH=16 this gives 0x7FFF or 0xFFFF.
  - Undefined: on overflow, the magnitude wraps (carry dropped). The sign is kept unless the magnitude is 0, in which case the sign is 0.
  - ovf is identical in both builds.

## Test plan
- a=0x0005, b=0x0003, op=0 (WIDTH=16) -> done 16 cycles after accept, result=0x0008, ovf=0; busy high for exactly 15 cycles.
- a=0x0003, b=0x8005, op=0 -> NEG path taken, done 31 cycles after accept, result=0x8002, ovf=0.
- a=0x0005, b=0x0005, op=1, then a=0x8000, b=0x8000, op=0 -> result=0x0000 in both cases, never 0x8000; second start issued in the done cycle is accepted.
- a=0x7FFF, b=0x0001 and a=0xFFFF, b=0x8001 -> ovf=1 in both cases:
  - without SM_ADDSUB_SAT_EN: result=0x0000 for both;
  - with SM_ADDSUB_SAT_EN: result=0x7FFF and 0xFFFF respectively.
- Start pulsed with different operands while busy=1 -> ignored; the result matches the first operands.
- reset asserted 8 cycles into an operation -> next cycle busy=0, done=0, result=0, ovf=0. A new start on the following cycle completes with correct latency and value.
